// File: rtl/mat2_mul_serial.sv
// mat2_mul_serial: serial 2x2 signed fixed-point matrix multiplier, C = A * B.
// A single N x N signed multiplier is time-shared over eight steps. Each output
// element is the sum of two products. That sum is rounded half toward +inf to
// Q(N-FRAC).FRAC and then saturated to N bits.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 request, sampled only in idle
//   a11..a22, b11..b22    operand matrices, captured on the accepting edge
//   busy                  high from the accepting edge until done deasserts
//   done                  one-cycle pulse, results valid from this cycle
//   c11..c22              result registers, held until the next done
//   sat                   OR of the per-element saturation flags of the last result
module mat2_mul_serial #(
  parameter int unsigned N    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] a11,
  input  logic signed [N-1:0] a12,
  input  logic signed [N-1:0] a21,
  input  logic signed [N-1:0] a22,
  input  logic signed [N-1:0] b11,
  input  logic signed [N-1:0] b12,
  input  logic signed [N-1:0] b21,
  input  logic signed [N-1:0] b22,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] c11,
  output logic signed [N-1:0] c12,
  output logic signed [N-1:0] c21,
  output logic signed [N-1:0] c22,
  output logic                sat
);

  localparam int unsigned PW = 2 * N;
  // Two guard bits so that adding the rounding constant can never wrap.
  localparam int unsigned SW = 2 * N + 2;

  localparam logic signed [SW-1:0] RndK = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MaxV = (SW'(1) << (N - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MinV = -(SW'(1) << (N - 1));

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [2:0]          step_q;
  logic signed [PW-1:0] acc_q;
  logic signed [N-1:0] a11_q, a12_q, a21_q, a22_q;
  logic signed [N-1:0] b11_q, b12_q, b21_q, b22_q;
  logic signed [N-1:0] s11_q, s12_q, s21_q;
  logic [2:0]          sat_scr_q;

  logic signed [N-1:0]  op_x, op_y;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum_rnd;
  logic signed [SW-1:0] rnd;
  logic                 ovf_hi, ovf_lo, sat_now;
  logic signed [N-1:0]  res;

  // Operand selection for the shared multiplier, in step order.
  always_comb begin
    op_x = '0;
    op_y = '0;
    case (step_q)
      3'd0:    begin op_x = a11_q; op_y = b11_q; end
      3'd1:    begin op_x = a12_q; op_y = b21_q; end
      3'd2:    begin op_x = a11_q; op_y = b12_q; end
      3'd3:    begin op_x = a12_q; op_y = b22_q; end
      3'd4:    begin op_x = a21_q; op_y = b11_q; end
      3'd5:    begin op_x = a22_q; op_y = b21_q; end
      3'd6:    begin op_x = a21_q; op_y = b12_q; end
      3'd7:    begin op_x = a22_q; op_y = b22_q; end
      default: begin op_x = '0;    op_y = '0;    end
    endcase
  end

  assign prod = PW'(op_x) * PW'(op_y);

  // Round half toward +inf, then clamp to the N-bit signed range.
  always_comb begin
    sum_rnd = SW'(acc_q) + SW'(prod) + RndK;
    rnd     = sum_rnd >>> FRAC;
    ovf_hi  = rnd > MaxV;
    ovf_lo  = rnd < MinV;
    sat_now = ovf_hi | ovf_lo;
    if (ovf_hi) begin
      res = MaxV[N-1:0];
    end else if (ovf_lo) begin
      res = MinV[N-1:0];
    end else begin
      res = rnd[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      acc_q     <= '0;
      a11_q     <= '0;
      a12_q     <= '0;
      a21_q     <= '0;
      a22_q     <= '0;
      b11_q     <= '0;
      b12_q     <= '0;
      b21_q     <= '0;
      b22_q     <= '0;
      s11_q     <= '0;
      s12_q     <= '0;
      s21_q     <= '0;
      sat_scr_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
      c11       <= '0;
      c12       <= '0;
      c21       <= '0;
      c22       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a11_q     <= a11;
            a12_q     <= a12;
            a21_q     <= a21;
            a22_q     <= a22;
            b11_q     <= b11;
            b12_q     <= b12;
            b21_q     <= b21;
            b22_q     <= b22;
            step_q    <= '0;
            acc_q     <= '0;
            sat_scr_q <= '0;
            sat       <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          step_q <= step_q + 3'd1;
          if (!step_q[0]) begin
            acc_q <= prod;
          end else begin
            // Odd step completes one element; c22 goes straight to the output.
            case (step_q[2:1])
              2'd0: begin s11_q <= res; sat_scr_q[0] <= sat_now; end
              2'd1: begin s12_q <= res; sat_scr_q[1] <= sat_now; end
              2'd2: begin s21_q <= res; sat_scr_q[2] <= sat_now; end
              default: begin
                c11     <= s11_q;
                c12     <= s12_q;
                c21     <= s21_q;
                c22     <= res;
                sat     <= (|sat_scr_q) | sat_now;
                done    <= 1'b1;
                state_q <= StDone;
              end
            endcase
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat2_mul_serial.sv
// Bench for mat2_mul_serial: directed cases plus random operands checked against
// a wide-integer matrix-product model with rounding and saturation.
module tb_mat2_mul_serial;

  localparam int S = 65536;

  logic clk, rst_n, start;
  logic signed [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic busy, done, sat;
  logic signed [31:0] c11, c12, c21, c22;

  mat2_mul_serial #(.N(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .busy(busy), .done(done),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic signed [31:0] av [4];  // 11, 12, 21, 22
  logic signed [31:0] bv [4];
  logic signed [31:0] exp_c [4];
  logic exp_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One element: x0*y0 + x1*y1, round half up at bit 16, clamp to 32 bits.
  function automatic logic [32:0] elem(input logic signed [31:0] x0, input logic signed [31:0] y0,
                                       input logic signed [31:0] x1, input logic signed [31:0] y1);
    logic signed [67:0] p0, q0, p1, q1, s, r;
    p0 = x0; q0 = y0; p1 = x1; q1 = y1;
    s = p0 * q0 + p1 * q1;
    r = (s + 68'sd32768) >>> 16;
    if (r > 68'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (r < -68'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, r[31:0]};
  endfunction

  task automatic model();
    logic [32:0] e [4];
    e[0] = elem(av[0], bv[0], av[1], bv[2]);
    e[1] = elem(av[0], bv[1], av[1], bv[3]);
    e[2] = elem(av[2], bv[0], av[3], bv[2]);
    e[3] = elem(av[2], bv[1], av[3], bv[3]);
    exp_sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_c[i] = e[i][31:0];
      exp_sat |= e[i][32];
    end
  endtask

  task automatic apply();
    a11 = av[0]; a12 = av[1]; a21 = av[2]; a22 = av[3];
    b11 = bv[0]; b12 = bv[1]; b21 = bv[2]; b22 = bv[3];
  endtask

  task automatic set_ops(input logic signed [31:0] x0, x1, x2, x3, y0, y1, y2, y3);
    av[0] = x0; av[1] = x1; av[2] = x2; av[3] = x3;
    bv[0] = y0; bv[1] = y1; bv[2] = y2; bv[3] = y3;
  endtask

  function automatic logic signed [31:0] rnd_val(input int mode);
    logic signed [31:0] edges [5];
    edges[0] = 32'h7FFFFFFF; edges[1] = 32'h80000000; edges[2] = 0;
    edges[3] = S; edges[4] = -S;
    case (mode)
      0: return $urandom;
      1: return $signed(32'($urandom_range(0, 32'h001FFFFF))) - 32'sh00100000;
      default: return edges[$urandom_range(0, 4)];
    endcase
  endfunction

  // Run one operation starting at the next falling edge; start is held for
  // 'hold' accepting-or-later edges. Optionally scramble the inputs mid-op and
  // pulse start during the done cycle.
  task automatic run_op(input string tag, input int hold, input bit mutate, input bit pulse_done);
    model();
    @(negedge clk);
    apply();
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy@E0"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= hold) start = 1'b0;
      if (mutate && k == 2) begin
        for (int i = 0; i < 4; i++) begin
          av[i] = $urandom;
          bv[i] = $urandom;
        end
        apply();
      end
      if (pulse_done && k == 9) start = 1'b1;
      @(posedge clk);
      #1;
      if (k < 8) begin
        check({tag, " done early"}, 32'(done), 32'd0);
      end else if (k == 8) begin
        check({tag, " done@8"}, 32'(done), 32'd1);
        check({tag, " busy@8"}, 32'(busy), 32'd1);
        check({tag, " c11"}, c11, exp_c[0]);
        check({tag, " c12"}, c12, exp_c[1]);
        check({tag, " c21"}, c21, exp_c[2]);
        check({tag, " c22"}, c22, exp_c[3]);
        check({tag, " sat"}, 32'(sat), 32'(exp_sat));
      end else begin
        check({tag, " done@9"}, 32'(done), 32'd0);
        check({tag, " busy@9"}, 32'(busy), 32'd0);
      end
    end
    if (!pulse_done) start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sat", 32'(sat), 32'd0);
    check("rst c11", c11, 32'd0);
    check("rst c22", c22, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_ops(2 * S, 0, 0, 4 * S, S / 2, 0, 0, S / 4);
    run_op("diag", 1, 1'b0, 1'b0);

    set_ops(S, 2 * S, 3 * S, 4 * S, 5 * S, 6 * S, 7 * S, 8 * S);
    run_op("mul2", 1, 1'b0, 1'b0);

    set_ops(1, 0, 0, -1, S / 2, 0, 0, S / 2);
    run_op("round", 1, 1'b0, 1'b0);

    set_ops(32767 * S, 32767 * S, 0, 0, S, 0, S, 0);
    run_op("satur", 1, 1'b0, 1'b0);
    set_ops(S, 2 * S, 3 * S, 4 * S, 5 * S, 6 * S, 7 * S, 8 * S);
    run_op("satclr", 1, 1'b0, 1'b0);

    // Long start, operands scrambled after accept, start pulsed in DONE,
    // then an immediate back-to-back accept at E10.
    set_ops(3 * S, -S, S / 4, 7, -2 * S, S, 9 * S, -S / 8);
    run_op("proto", 3, 1'b1, 1'b1);
    set_ops(-3 * S, S, 5, S / 3, 2 * S, -S, 11, 4 * S);
    run_op("b2b", 1, 1'b0, 1'b0);

    // Reset in the middle of a run: everything clears, no done appears.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort c11", c11, 32'd0);
    check("abort c12", c12, 32'd0);
    check("abort c21", c21, 32'd0);
    check("abort c22", c22, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort no done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(S, 2 * S, 3 * S, 4 * S, 5 * S, 6 * S, 7 * S, 8 * S);
    run_op("post rst", 1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = rnd_val(n % 3);
        bv[i] = rnd_val((n + i) % 3);
      end
      run_op("rand", 1 + (n % 2), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
